// File: rtl/sentinel_stream_writer.sv
// Sentinel-terminated stream producer: forwards a counted payload, then appends the sentinel word.
// Optional masked collision detector enabled by defining SENTINEL_WRITER_COLLISION_CHECK_EN.
module sentinel_stream_writer #(
  parameter int unsigned WORD_WIDTH  = 36,
  parameter int unsigned COUNT_WIDTH = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cfg_write_i,
  input  logic [WORD_WIDTH-1:0]  cfg_sentinel_i,
  input  logic [WORD_WIDTH-1:0]  cfg_mask_i,
  output logic [WORD_WIDTH-1:0]  sentinel_o,
  output logic [WORD_WIDTH-1:0]  mask_o,
  output logic [WORD_WIDTH-1:0]  sentinel_masked_o,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] length_i,
  output logic                   busy_o,
  input  logic [WORD_WIDTH-1:0]  in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [WORD_WIDTH-1:0]  out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_last_o,
  output logic                   collision_o,
  output logic [COUNT_WIDTH-1:0] collision_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TERM    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [WORD_WIDTH-1:0]  sentinel_q, sentinel_d;
  logic [WORD_WIDTH-1:0]  mask_q, mask_d;
  logic [WORD_WIDTH-1:0]  sent_masked_q, sent_masked_d;
  logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;

  logic slot_free;
  logic accept;

  assign slot_free  = !out_valid_q || out_ready_i;
  assign in_ready_o = (state_q == PAYLOAD) && slot_free;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      sentinel_q    <= '0;
      mask_q        <= '0;
      sent_masked_q <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      sentinel_q    <= sentinel_d;
      mask_q        <= mask_d;
      sent_masked_q <= sent_masked_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    sentinel_d    = sentinel_q;
    mask_d        = mask_q;
    sent_masked_d = sent_masked_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;

    // A drained beat frees the output register; a load below overrides this.
    if (out_ready_i) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_write_i) begin
          sentinel_d    = cfg_sentinel_i;
          mask_d        = cfg_mask_i;
          sent_masked_d = cfg_sentinel_i & ~cfg_mask_i;
        end
        if (start_i) begin
          remaining_d = length_i;
          state_d     = (length_i == '0) ? TERM : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          out_data_d  = in_data_i;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_WIDTH'(1)) state_d = TERM;
        end
      end
      TERM: begin
        if (slot_free) begin
          out_data_d  = sentinel_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sentinel_o        = sentinel_q;
  assign mask_o            = mask_q;
  assign sentinel_masked_o = sent_masked_q;
  assign busy_o            = (state_q != IDLE);
  assign out_data_o        = out_data_q;
  assign out_valid_o       = out_valid_q;
  assign out_last_o        = out_last_q;

`ifdef SENTINEL_WRITER_COLLISION_CHECK_EN
  logic                   collision_q, collision_d;
  logic [COUNT_WIDTH-1:0] coll_cnt_q, coll_cnt_d;
  logic                   hit;

  // Registered so the pulse lines up with the beat on out_data_o.
  assign hit = accept && ((in_data_i & ~mask_q) == sent_masked_q);

  always_comb begin
    collision_d = hit;
    coll_cnt_d  = coll_cnt_q;
    if (hit && (coll_cnt_q != '1)) coll_cnt_d = coll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      collision_q <= 1'b0;
      coll_cnt_q  <= '0;
    end else begin
      collision_q <= collision_d;
      coll_cnt_q  <= coll_cnt_d;
    end
  end

  assign collision_o       = collision_q;
  assign collision_count_o = coll_cnt_q;
`else
  assign collision_o       = 1'b0;
  assign collision_count_o = '0;
`endif

endmodule

// File: doc/sentinel_stream_writer.md
# sentinel_stream_writer

Producer side of sentinel-terminated word streams. Accepts a start command with a payload length, forwards exactly that many words from an input valid/ready stream to an output valid/ready stream, then appends the configured sentinel word as the terminator. Holds the sentinel and mask configuration registers and publishes the pre-masked sentinel, so downstream masked-match checkers see the same value. Optionally flags payload words that a downstream checker would mistake for the terminator.

## Interface
- WORD_WIDTH, 36, data, sentinel and mask width
- COUNT_WIDTH, 10, width of the length and collision counters
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_write  in  1  load cfg_sentinel/cfg_mask; honoured only in IDLE
- cfg_sentinel  in  WORD_WIDTH  terminator word
- cfg_mask  in  WORD_WIDTH  1 = bit excluded from match
- sentinel  out  WORD_WIDTH  current sentinel register
- mask  out  WORD_WIDTH  current mask register
- sentinel_masked  out  WORD_WIDTH  registered sentinel & ~mask
- start  in  1  begin a frame; honoured only in IDLE
- length  in  COUNT_WIDTH  payload word count, sampled with start
- busy  out  1  high in PAYLOAD or TERM
- in_data / in_valid / in_ready  in/in/out  WORD_WIDTH/1/1  payload input stream
- out_data / out_valid / out_ready  out/out/in  WORD_WIDTH/1/1  output stream
- out_last  out  1  high with the terminator word
- collision  out  1  one-cycle pulse when an accepted payload word matches under mask
- collision_count  out  COUNT_WIDTH  saturating collision total

## Operation
- Config: cfg_write in IDLE loads sentinel <= cfg_sentinel, mask <= cfg_mask, sentinel_masked <= cfg_sentinel & ~cfg_mask, all on the same edge. cfg_write outside IDLE is ignored.
- FSM states: IDLE, PAYLOAD, TERM.
  - IDLE + start: remaining <= length; next state is PAYLOAD, or TERM if length == 0.
  - PAYLOAD: in_ready = !out_valid || out_ready. Each in_valid && in_ready loads the output register with in_data, sets out_last = 0 and decrements remaining.
  - Accepting the word that takes remaining from 1 to 0 moves the FSM to TERM.
  - TERM: when the output register is free (!out_valid || out_ready), load out_data = sentinel, out_last = 1, out_valid = 1, then go to IDLE.
  - start in PAYLOAD or TERM is ignored.
- Output stage: one register. out_valid clears on out_ready when nothing new is loaded. out_data, out_valid and out_last hold while out_valid && !out_ready.
- Collision check: accepted payload word with (in_data & ~mask) == sentinel_masked gives collision = 1 for one cycle and collision_count += 1, saturating at all-ones. The word is still forwarded unchanged.
- collision_count clears only on reset.
- All-ones mask: every payload word collides.
- All-zero mask: exact comparison.

## Timing
- Reset (async assert, clears immediately):
  - state IDLE
  - sentinel = mask = sentinel_masked = 0
  - out_valid = out_last = 0, out_data = 0
  - busy = 0, in_ready = 0, collision = 0, collision_count = 0
- Reset mid-frame abandons the frame with no terminator. out_valid drops asynchronously.
- Latency: in_data to out_data 1 cycle. start to busy 1 cycle.
- With out_ready held high, an N-word frame takes N+1 out_valid cycles, with the terminator in the cycle after the last payload word.
- Throughput: 1 word/cycle with out_ready high.
- Simultaneous output drain and load in the same cycle is allowed (full rate).
- Last payload word accepted and TERM entered on the same edge: the terminator follows on the next free slot.
- length = all-ones is legal. There is no wrap.
- collision is registered and aligned with the cycle the word appears on out_data.

## Configuration
- SENTINEL_WRITER_COLLISION_CHECK_EN defined: collision comparator, pulse and saturating counter are present as described.
- Not defined: collision and collision_count are tied to 0 and no comparator is built. All other behaviour is identical.

## Test plan
- Reset, cfg_write sentinel=36'hF_FFFF_FFFF mask=0, start length=3, words 1,2,3, out_ready=1 -> out_data 1,2,3,F_FFFF_FFFF on consecutive cycles, out_last only on the 4th, busy low after.
- start length=0 -> a single terminator beat with out_last=1, in_ready never high.
- length=4 with out_ready toggling 1,0,0,1,... -> no loss or duplication, out_data stable while stalled, exactly 5 beats.
- Macro on, sentinel=36'h0_0000_00AB, mask=36'hF_FFFF_FF00, payload 36'h1_2345_67AB -> collision pulse on its out beat, count=1; word forwarded unchanged.
- cfg_write and start asserted during PAYLOAD -> both ignored; sentinel_masked unchanged, frame length unaffected.
- Assert reset_n=0 mid-frame after 2 of 5 words -> out_valid/busy drop immediately, then a fresh length=1 frame completes normally with sentinel=0.
